// File: rtl/can_if_pkg.sv
// Shared definitions for the bus-to-CAN bridge: FSM state codes, local
// register offsets, bus RW encoding and a counter-width helper.
package can_if_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_REQ      = 2'd1;
    localparam state_t ST_RESP     = 2'd2;
    localparam state_t ST_WAIT_REL = 2'd3;

    // Offsets of the bridge-local registers relative to LOCAL_BASE
    localparam int unsigned IRQ_PEND_OFS = 0;
    localparam int unsigned IRQ_MASK_OFS = 1;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Bits needed to hold 0..max_val, never less than one bit
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/can_irq_ctrl.sv
// Interrupt controller for the bridge: rising-edge detection on the CAN
// interrupt lines, sticky write-1-to-clear pending bits, a mask register
// and a registered combined interrupt output.
module can_irq_ctrl #(
    parameter int N_IRQ = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] i_irq,
    input  logic             i_wr_pend,
    input  logic             i_wr_mask,
    input  logic [N_IRQ-1:0] i_wdata,
    output logic [N_IRQ-1:0] o_pend,
    output logic [N_IRQ-1:0] o_mask,
    output logic             o_irq
);

    logic [N_IRQ-1:0] r_prev;
    logic [N_IRQ-1:0] r_pend;
    logic [N_IRQ-1:0] r_mask;
    logic             r_irq;
    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_clr;

    assign w_rise = i_irq & ~r_prev;
    assign w_clr  = i_wr_pend ? i_wdata : '0;

    // Edge detect, pending (a new edge wins over a clear), mask, and output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_pend <= '0;
            r_mask <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_prev <= i_irq;
            r_pend <= (r_pend & ~w_clr) | w_rise;
            if (i_wr_mask) begin
                r_mask <= i_wdata;
            end
            r_irq  <= |(r_pend & r_mask);
        end
    end

    assign o_pend = r_pend;
    assign o_mask = r_mask;
    assign o_irq  = r_irq;

endmodule

// File: rtl/can_bus_bridge.sv
// Bus-to-CAN-core access bridge. Turns a level-held bus request into a single
// handshaked CAN transaction with timeout, serves the local IRQ pending/mask
// registers, and stretches the CAN core reset after bus reset release.
module can_bus_bridge
    import can_if_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 8,
    parameter int                N_IRQ       = 4,
    parameter int                TIMEOUT_CYC = 255,
    parameter logic [ADDR_W-1:0] LOCAL_BASE  = 8'hF0,
    parameter int                RST_HOLD    = 2
) (
    input  logic              sys_clk,
    input  logic              Bus2IP_reset_n,
    input  logic              Bus2IP_CS,
    input  logic              Bus2IP_RW,
    input  logic [DATA_W-1:0] Bus2IP_data,
    input  logic [ADDR_W-1:0] Bus2IP_addr,
    output logic [DATA_W-1:0] IP2Bus_data,
    output logic              IP2Bus_ack,
    output logic              IP2Bus_interrupt,
    output logic              IP2Bus_error,
    output logic              IP2Can_reset,
    output logic              IP2Can_CS,
    output logic              IP2Can_RW,
    output logic [DATA_W-1:0] IP2Can_data,
    output logic [ADDR_W-1:0] IP2Can_addr,
    input  logic [DATA_W-1:0] Can2IP_data,
    input  logic              Can2IP_ack,
    input  logic [N_IRQ-1:0]  Can2IP_interrupt,
    input  logic              Can2IP_error
);

    localparam int CNT_W  = cnt_width(TIMEOUT_CYC);
    localparam int HOLD_W = cnt_width(RST_HOLD);
    localparam logic [ADDR_W-1:0] PEND_ADDR = LOCAL_BASE + ADDR_W'(IRQ_PEND_OFS);
    localparam logic [ADDR_W-1:0] MASK_ADDR = LOCAL_BASE + ADDR_W'(IRQ_MASK_OFS);

    state_t            r_state;
    logic              r_can_cs;
    logic              r_can_rw;
    logic [ADDR_W-1:0] r_can_addr;
    logic [DATA_W-1:0] r_can_data;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;
    logic [HOLD_W-1:0] r_hold;
    logic              r_can_rst;

    logic              w_start;
    logic              w_hit_pend;
    logic              w_hit_mask;
    logic              w_wr_pend;
    logic              w_wr_mask;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_timeout;
    logic [N_IRQ-1:0]  w_pend;
    logic [N_IRQ-1:0]  w_mask;
    logic [DATA_W-1:0] w_local_rdata;

    // A request is only taken from IDLE and never while the CAN core is held in reset
    assign w_start    = (r_state == ST_IDLE) && Bus2IP_CS && !r_can_rst;
    assign w_hit_pend = (Bus2IP_addr == PEND_ADDR);
    assign w_hit_mask = (Bus2IP_addr == MASK_ADDR);
    assign w_wr_pend  = w_start && w_hit_pend && (Bus2IP_RW == RW_WRITE);
    assign w_wr_mask  = w_start && w_hit_mask && (Bus2IP_RW == RW_WRITE);

    // Timeout fires on the cycle the request has been out for TIMEOUT_CYC cycles
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_timeout  = (TIMEOUT_CYC != 0) && (w_cnt_inc == CNT_W'(TIMEOUT_CYC));

    // Zero-extended readback of the local registers
    always_comb begin
        w_local_rdata = '0;
        if (w_hit_pend) begin
            w_local_rdata[N_IRQ-1:0] = w_pend;
        end else if (w_hit_mask) begin
            w_local_rdata[N_IRQ-1:0] = w_mask;
        end
    end

    // Keep the CAN core in reset for RST_HOLD clock edges after bus reset release
    always_ff @(posedge sys_clk or negedge Bus2IP_reset_n) begin
        if (!Bus2IP_reset_n) begin
            r_hold    <= HOLD_W'(RST_HOLD);
            r_can_rst <= 1'b1;
        end else begin
            if (r_hold != '0) begin
                r_hold <= r_hold - HOLD_W'(1);
            end
            r_can_rst <= (r_hold > HOLD_W'(1));
        end
    end

    // Transaction FSM: capture, CAN handshake with timeout, one-cycle response, release wait
    always_ff @(posedge sys_clk or negedge Bus2IP_reset_n) begin
        if (!Bus2IP_reset_n) begin
            r_state    <= ST_IDLE;
            r_can_cs   <= 1'b0;
            r_can_rw   <= 1'b0;
            r_can_addr <= '0;
            r_can_data <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_can_rw   <= Bus2IP_RW;
                        r_can_addr <= Bus2IP_addr;
                        r_can_data <= Bus2IP_data;
                        r_cnt      <= '0;
                        if (w_hit_pend || w_hit_mask) begin
                            r_rdata <= (Bus2IP_RW == RW_READ) ? w_local_rdata : '0;
                            r_err   <= 1'b0;
                            r_state <= ST_RESP;
                        end else begin
                            r_can_cs <= 1'b1;
                            r_state  <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (Can2IP_ack) begin
                        r_can_cs <= 1'b0;
                        r_rdata  <= (r_can_rw == RW_READ) ? Can2IP_data : '0;
                        r_err    <= Can2IP_error;
                        r_state  <= ST_RESP;
                    end else if (w_timeout) begin
                        r_can_cs <= 1'b0;
                        r_rdata  <= '0;
                        r_err    <= 1'b1;
                        r_state  <= ST_RESP;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_WAIT_REL;
                end
                ST_WAIT_REL: begin
                    if (!Bus2IP_CS) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    can_irq_ctrl #(
        .N_IRQ (N_IRQ)
    ) u_irq (
        .clk       (sys_clk),
        .rst_n     (Bus2IP_reset_n),
        .i_irq     (Can2IP_interrupt),
        .i_wr_pend (w_wr_pend),
        .i_wr_mask (w_wr_mask),
        .i_wdata   (Bus2IP_data[N_IRQ-1:0]),
        .o_pend    (w_pend),
        .o_mask    (w_mask),
        .o_irq     (IP2Bus_interrupt)
    );

    assign IP2Bus_ack   = (r_state == ST_RESP);
    assign IP2Bus_error = (r_state == ST_RESP) && r_err;
    assign IP2Bus_data  = (r_state == ST_RESP) ? r_rdata : '0;
    assign IP2Can_reset = r_can_rst;
    assign IP2Can_CS    = r_can_cs;
    assign IP2Can_RW    = r_can_rw;
    assign IP2Can_data  = r_can_data;
    assign IP2Can_addr  = r_can_addr;

endmodule

// File: tb/tb_can_bus_bridge.sv
// Scoreboard bench for can_bus_bridge: stimulus pushes expected bus responses
// and expected CAN-side requests; a bus monitor and a CAN responder check them.
module tb_can_bus_bridge;

    localparam int TO = 8;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        chk_data;
    } resp_t;

    typedef struct {
        logic        rw;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] rdata;
        logic        err;
        int          dur;
    } can_t;

    logic        sys_clk;
    logic        Bus2IP_reset_n;
    logic        Bus2IP_CS;
    logic        Bus2IP_RW;
    logic [31:0] Bus2IP_data;
    logic [7:0]  Bus2IP_addr;
    logic [31:0] IP2Bus_data;
    logic        IP2Bus_ack;
    logic        IP2Bus_interrupt;
    logic        IP2Bus_error;
    logic        IP2Can_reset;
    logic        IP2Can_CS;
    logic        IP2Can_RW;
    logic [31:0] IP2Can_data;
    logic [7:0]  IP2Can_addr;
    logic [31:0] Can2IP_data;
    logic        Can2IP_ack;
    logic [3:0]  Can2IP_interrupt;
    logic        Can2IP_error;

    resp_t sb_q[$];
    can_t  can_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    n_can_cs = 0;
    int    exp_can_cs = 0;

    // Reference state of the local registers and the interrupt input levels
    logic [3:0] m_pend = 4'h0;
    logic [3:0] m_mask = 4'h0;
    logic [3:0] irq_lvl = 4'h0;

    can_bus_bridge #(
        .DATA_W(32), .ADDR_W(8), .N_IRQ(4), .TIMEOUT_CYC(TO),
        .LOCAL_BASE(8'hF0), .RST_HOLD(2)
    ) dut (
        .sys_clk(sys_clk), .Bus2IP_reset_n(Bus2IP_reset_n),
        .Bus2IP_CS(Bus2IP_CS), .Bus2IP_RW(Bus2IP_RW),
        .Bus2IP_data(Bus2IP_data), .Bus2IP_addr(Bus2IP_addr),
        .IP2Bus_data(IP2Bus_data), .IP2Bus_ack(IP2Bus_ack),
        .IP2Bus_interrupt(IP2Bus_interrupt), .IP2Bus_error(IP2Bus_error),
        .IP2Can_reset(IP2Can_reset), .IP2Can_CS(IP2Can_CS),
        .IP2Can_RW(IP2Can_RW), .IP2Can_data(IP2Can_data),
        .IP2Can_addr(IP2Can_addr), .Can2IP_data(Can2IP_data),
        .Can2IP_ack(Can2IP_ack), .Can2IP_interrupt(Can2IP_interrupt),
        .Can2IP_error(Can2IP_error)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Change interrupt levels; any 0->1 bit becomes pending in the model
    task automatic set_irq(input logic [3:0] lvl);
        @(negedge sys_clk);
        m_pend |= lvl & ~irq_lvl;
        irq_lvl = lvl;
        Can2IP_interrupt = lvl;
    endtask

    task automatic chk_irq();
        repeat (2) @(negedge sys_clk);
        chk("irq_out", 32'(IP2Bus_interrupt), 32'(|(m_pend & m_mask)));
    endtask

    // One bus transaction. dly = cycles the CAN core waits before acking
    // (>= TO means it never acks in time). irq_rise = interrupt bits raised
    // on the same edge that samples the request.
    task automatic bus_txn(input logic rw, input logic [7:0] addr, input logic [31:0] wd,
                           input int dly, input logic [31:0] cd, input logic ce,
                           input int hold_extra, input logic [3:0] irq_rise);
        resp_t r;
        can_t  c;
        logic [3:0] rise;
        int n;
        @(negedge sys_clk);
        Bus2IP_CS   = 1'b1;
        Bus2IP_RW   = rw;
        Bus2IP_addr = addr;
        Bus2IP_data = wd;
        rise = irq_rise & ~irq_lvl;
        irq_lvl = irq_lvl | irq_rise;
        Can2IP_interrupt = irq_lvl;
        if (addr == 8'hF0 || addr == 8'hF1) begin
            r.err = 1'b0;
            r.chk_data = rw;
            r.data = {28'd0, (addr == 8'hF0) ? m_pend : m_mask};
            if (!rw && addr == 8'hF0) m_pend = m_pend & ~wd[3:0];
            if (!rw && addr == 8'hF1) m_mask = wd[3:0];
            m_pend = m_pend | rise;
        end else begin
            m_pend = m_pend | rise;
            c.rw = rw; c.addr = addr; c.wdata = wd; c.dly = dly;
            c.rdata = cd; c.err = ce;
            c.dur = (dly < TO) ? dly + 1 : TO;
            can_q.push_back(c);
            exp_can_cs++;
            r.err = (dly < TO) ? ce : 1'b1;
            r.data = (dly < TO) ? cd : 32'h0;
            r.chk_data = rw || (dly >= TO);
        end
        sb_q.push_back(r);
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!IP2Bus_ack && n < 60);
        chk("ack_seen", 32'(IP2Bus_ack), 32'h1);
        repeat (hold_extra) @(negedge sys_clk);
        Bus2IP_CS = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    // Bus monitor: every ack pops one expected response
    initial begin
        resp_t e;
        forever begin
            @(negedge sys_clk);
            if (IP2Bus_ack) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_ack: ack with nothing outstanding, data=0x%0h", IP2Bus_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_error", 32'(IP2Bus_error), 32'(e.err));
                    if (e.chk_data) chk("resp_data", IP2Bus_data, e.data);
                end
            end else if (IP2Bus_error) begin
                n_checks++;
                n_errors++;
                $display("FAIL stray_error: error=1 without ack, expected 0");
            end
        end
    end

    // CAN core model: checks each request against the expected one and acks after dly cycles
    initial begin
        can_t cur;
        bit   in_req;
        int   hi_cnt;
        in_req = 0;
        hi_cnt = 0;
        cur = '{rw: 1'b0, addr: 8'h0, wdata: 32'h0, dly: 1000, rdata: 32'h0, err: 1'b0, dur: 0};
        Can2IP_ack = 1'b0;
        Can2IP_data = 32'h0;
        Can2IP_error = 1'b0;
        forever begin
            @(negedge sys_clk);
            Can2IP_ack = 1'b0;
            Can2IP_error = 1'b0;
            Can2IP_data = 32'h0;
            if (!Bus2IP_reset_n) begin
                in_req = 0;
            end else if (IP2Can_CS) begin
                if (!in_req) begin
                    in_req = 1;
                    hi_cnt = 0;
                    n_can_cs++;
                    if (can_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_can_cs: CS=1 addr=0x%0h with no request pending", IP2Can_addr);
                        cur.dly = 1000;
                        cur.dur = TO;
                    end else begin
                        cur = can_q.pop_front();
                    end
                end
                chk("can_addr", 32'(IP2Can_addr), 32'(cur.addr));
                chk("can_rw", 32'(IP2Can_RW), 32'(cur.rw));
                if (!cur.rw) chk("can_wdata", IP2Can_data, cur.wdata);
                if (hi_cnt == cur.dly) begin
                    Can2IP_ack = 1'b1;
                    Can2IP_data = cur.rdata;
                    Can2IP_error = cur.err;
                end
                hi_cnt++;
            end else if (in_req) begin
                in_req = 0;
                chk("can_cs_len", hi_cnt, cur.dur);
            end
        end
    end

    // Stimulus
    initial begin
        int n;
        int sel;
        logic [7:0] a;
        Bus2IP_reset_n = 1'b0;
        Bus2IP_CS = 1'b0;
        Bus2IP_RW = 1'b0;
        Bus2IP_data = 32'h0;
        Bus2IP_addr = 8'h0;
        Can2IP_interrupt = 4'h0;
        repeat (3) @(negedge sys_clk);
        chk("rst_ack", 32'(IP2Bus_ack), 32'h0);
        chk("rst_err", 32'(IP2Bus_error), 32'h0);
        chk("rst_irq", 32'(IP2Bus_interrupt), 32'h0);
        chk("rst_can_cs", 32'(IP2Can_CS), 32'h0);
        chk("rst_can_reset", 32'(IP2Can_reset), 32'h1);
        chk("rst_data", IP2Bus_data, 32'h0);
        Bus2IP_reset_n = 1'b1;
        @(negedge sys_clk);
        chk("can_reset_hold1", 32'(IP2Can_reset), 32'h1);
        @(negedge sys_clk);
        chk("can_reset_released", 32'(IP2Can_reset), 32'h0);

        bus_txn(1'b0, 8'h10, 32'h0000_00A5, 3, 32'h0, 1'b0, 0, 4'h0);
        bus_txn(1'b1, 8'h20, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 5, 4'h0);
        bus_txn(1'b1, 8'h30, 32'h0, 100, 32'h1234_5678, 1'b0, 0, 4'h0);
        bus_txn(1'b1, 8'h31, 32'h0, TO - 1, 32'h1234_5678, 1'b0, 0, 4'h0);
        bus_txn(1'b0, 8'h32, 32'h5555_0000, 0, 32'h0, 1'b1, 1, 4'h0);

        bus_txn(1'b0, 8'hF1, 32'hFFFF_FFF3, 0, 32'h0, 1'b0, 0, 4'h0);
        bus_txn(1'b1, 8'hF1, 32'h0, 0, 32'h0, 1'b0, 0, 4'h0);
        set_irq(4'h2);
        set_irq(4'h0);
        chk_irq();
        bus_txn(1'b1, 8'hF0, 32'h0, 0, 32'h0, 1'b0, 0, 4'h0);
        bus_txn(1'b0, 8'hF0, 32'h2, 0, 32'h0, 1'b0, 0, 4'h0);
        chk_irq();
        set_irq(4'h4);
        set_irq(4'h0);
        chk_irq();
        bus_txn(1'b1, 8'hF0, 32'h0, 0, 32'h0, 1'b0, 0, 4'h0);

        set_irq(4'h1);
        set_irq(4'h0);
        bus_txn(1'b0, 8'hF0, 32'h1, 0, 32'h0, 1'b0, 0, 4'h1);
        bus_txn(1'b1, 8'hF0, 32'h0, 0, 32'h0, 1'b0, 0, 4'h0);
        set_irq(4'h0);
        chk_irq();

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) a = 8'hF0;
            else if (sel == 1) a = 8'hF1;
            else a = 8'($urandom_range(0, 8'hEF));
            bus_txn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 10),
                    $urandom, ($urandom_range(0, 3) == 0), $urandom_range(0, 3), 4'h0);
            if ((i % 4) == 3) begin
                set_irq(4'($urandom_range(0, 15)));
                chk_irq();
            end
        end
        set_irq(4'h0);
        repeat (2) @(negedge sys_clk);

        // Reset while the CAN request is outstanding
        can_q.push_back('{rw: 1'b0, addr: 8'h40, wdata: 32'h0BAD_F00D, dly: 1000,
                          rdata: 32'h0, err: 1'b0, dur: 0});
        exp_can_cs++;
        @(negedge sys_clk);
        Bus2IP_CS = 1'b1;
        Bus2IP_RW = 1'b0;
        Bus2IP_addr = 8'h40;
        Bus2IP_data = 32'h0BAD_F00D;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!IP2Can_CS && n < 10);
        chk("mid_req_cs_up", 32'(IP2Can_CS), 32'h1);
        @(negedge sys_clk);
        @(posedge sys_clk);
        #2;
        Bus2IP_reset_n = 1'b0;
        #1;
        chk("mid_rst_can_cs", 32'(IP2Can_CS), 32'h0);
        chk("mid_rst_can_reset", 32'(IP2Can_reset), 32'h1);
        chk("mid_rst_ack", 32'(IP2Bus_ack), 32'h0);
        Bus2IP_CS = 1'b0;
        m_pend = 4'h0;
        m_mask = 4'h0;
        repeat (3) @(negedge sys_clk);
        Bus2IP_reset_n = 1'b1;
        @(negedge sys_clk);
        chk("mid_rst_hold1", 32'(IP2Can_reset), 32'h1);
        @(negedge sys_clk);
        chk("mid_rst_released", 32'(IP2Can_reset), 32'h0);
        repeat (3) @(negedge sys_clk);
        bus_txn(1'b1, 8'hF1, 32'h0, 0, 32'h0, 1'b0, 0, 4'h0);

        repeat (5) @(negedge sys_clk);
        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        chk("can_q_empty", 32'(can_q.size()), 32'h0);
        chk("can_cs_count", n_can_cs, exp_can_cs);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
